fft_input_framer: RTL and testbench
===================================

Name: fft_input_framer

Overview:
- Collects a stream of real 8-bit ADC samples (Q4.4) into one frame of N points.
- Sign-extends and rescales each sample to the FFT's 16-bit Q8.8 format.
- Presents the frame as the packed parallel bus, with x(0) in the MSB slice, that the 32-point FFT core expects on its data input.
- Issues a single-cycle fft_start pulse per frame, then enforces a hold-off gap before accepting the next frame. It sits directly upstream of the FFT core.

Parameters:
- N, 32, points per frame (power of 2).
- IN_WIDTH, 8, ADC sample width.
- IN_FRAC, 4, fractional bits of the input sample.
- WIDTH, 16, output point width.
- OUT_FRAC, 8, fractional bits of the output point. OUT_FRAC >= IN_FRAC and WIDTH >= IN_WIDTH+OUT_FRAC-IN_FRAC are required.
- HOLDOFF, 4, cycles after launch during which no samples are accepted (0 allowed).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, framer enable; low pauses acceptance.
- flush, input, 1, synchronous discard of the partial frame.
- sample_valid, input, 1, ADC sample present.
- sample_in, input, IN_WIDTH, signed Q4.4 sample.
- sample_ready, output, 1, framer accepts sample this cycle.
- frame_data, output, N*WIDTH, packed frame; x(k) at [(N-k)*WIDTH-1 -: WIDTH].
- fft_start, output, 1, one-cycle pulse when frame_data is updated.
- sample_idx, output, clog2(N), index of the next sample to be written.
- frame_count, output, 16, number of launched frames, wrapping.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: all state registers cleared.
  - frame_data = 0, fft_start = 0, sample_ready = 0, sample_idx = 0, frame_count = 0.
  - FSM = IDLE; collection buffer cleared.
- FSM states: IDLE, COLLECT, LAUNCH, HOLD.
  - IDLE -> COLLECT when en = 1.
  - COLLECT -> LAUNCH on acceptance of sample N-1.
  - LAUNCH -> HOLD when HOLDOFF > 0; otherwise LAUNCH -> COLLECT.
  - HOLD -> COLLECT after HOLDOFF cycles in HOLD.
- Ready and accept:
  - sample_ready = (state == COLLECT) && en && !flush. It is combinational from registered state plus en and flush.
  - Accept = sample_valid && sample_ready. sample_valid without ready is ignored; no internal buffering of unaccepted samples.
- Conversion per accepted sample:
  - out = sign_extend(sample_in) << (OUT_FRAC-IN_FRAC), truncated to WIDTH bits.
  - For the defaults this is {4{s[7]}, s, 4'b0}. Exact; no rounding or saturation is possible.
- Storage: accepted sample k is written into collection slot k; sample_idx then increments.
- Launch timing:
  - Sample N-1 accepted in cycle T. At the T+1 edge, the collection buffer is copied to frame_data, fft_start = 1 for exactly cycle T+1, and frame_count increments.
  - sample_idx returns to 0.
- Output stability: frame_data is stable from launch until the next launch, so the FFT may re-sample it at any time. Collection of the next frame never disturbs frame_data (double buffered).
- Throughput:
  - sample_ready is low in LAUNCH and for HOLDOFF cycles of HOLD.
  - Minimum frame period is N+1+HOLDOFF cycles with continuous valid.
- en low in COLLECT pauses collection; the partial frame and sample_idx are retained. Acceptance resumes when en returns. en has no effect in LAUNCH/HOLD, which run to completion.
- flush:
  - In COLLECT: sample_idx = 0, state stays COLLECT, frame_data untouched.
  - Flush coinciding with what would be sample N-1: no acceptance (ready is low), so no launch.
  - In LAUNCH/HOLD: ignored.
  - In IDLE: no effect.
- frame_count wraps 0xFFFF -> 0x0000.
- Asynchronous rst mid-frame or mid-HOLD: immediate return to reset values, including fft_start forced low within the same cycle.

Test Plan:
- Reset/idle: assert rst with en = 0 -> all outputs 0, sample_ready = 0. Release rst, raise en -> sample_ready = 1 the next cycle.
- Format and packing: stream samples 0x10, 0x80, 0x7F, 0xFF, then 28 x 0x00, valid continuous ->
  - fft_start pulses once, one cycle after the 32nd accept.
  - frame_data top slice = 0x0100; slices 1, 2, 3 = 0xF800, 0x07F0, 0xFFF0; remainder 0.
  - frame_count = 1.
- Throughput/hold-off: continuous valid, ramp samples 0x00..0x1F repeating -> fft_start pulses exactly every 37 cycles; sample_ready low for exactly 5 cycles after each 32nd accept.
- Pause and stability: drop en for 10 cycles after sample 15 -> sample_idx holds at 16 with no accepts. Resume -> launch occurs; frame_data is unchanged during the pause and during collection of the following frame.
- Flush: flush in the same cycle as a valid sample 31 -> no launch, sample_idx = 0, frame_count unchanged. 32 further samples -> launch containing only the post-flush samples.
- Async reset: assert rst asynchronously in the cycle fft_start is high, and again mid-frame at sample_idx = 20 -> fft_start drops immediately; frame_data = 0, frame_count = 0, state IDLE.

Source files
------------

// File: rtl/fft_input_framer.sv
// fft_input_framer
// Gathers N real ADC samples (signed IN_FRAC fixed point), widens each one to
// the FFT point format, and hands the completed frame to the FFT core as one
// packed bus with x(0) in the top slice. Each launch produces a one-cycle
// fft_start pulse and is followed by a hold-off gap.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | after reset; waits for en before accepting samples
//   COLLECT  | accepting samples into the collection buffer
//   LAUNCH   | frame_data just updated, fft_start high for this one cycle
//   HOLD     | hold-off gap of HOLDOFF cycles, no samples accepted
module fft_input_framer #(
    parameter int N        = 32,
    parameter int IN_WIDTH = 8,
    parameter int IN_FRAC  = 4,
    parameter int WIDTH    = 16,
    parameter int OUT_FRAC = 8,
    parameter int HOLDOFF  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  sample_valid,
    input  logic [IN_WIDTH-1:0]   sample_in,
    output logic                  sample_ready,
    output logic [N*WIDTH-1:0]    frame_data,
    output logic                  fft_start,
    output logic [$clog2(N)-1:0]  sample_idx,
    output logic [15:0]           frame_count
);

    localparam int IDX_W  = $clog2(N);
    localparam int SHIFT  = OUT_FRAC - IN_FRAC;
    // The hold counter counts down from HOLDOFF-1 to 0, so it only needs to
    // hold HOLDOFF-1.
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LAUNCH  = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    sample_idx_q, sample_idx_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [N*WIDTH-1:0]  frame_data_q, frame_data_d;
    logic                fft_start_q, fft_start_d;
    logic [WIDTH-1:0]    buf_q [N];
    logic [WIDTH-1:0]    buf_d [N];

    logic                         ready;
    logic                         accept;
    logic signed [IN_WIDTH-1:0]   sample_s;
    logic signed [WIDTH-1:0]      sample_ext;
    logic [WIDTH-1:0]             sample_conv;

    // Sign-extend to the output width, then move the binary point; exact, so
    // no rounding or saturation is needed.
    assign sample_s    = sample_in;
    assign sample_ext  = WIDTH'(sample_s);
    assign sample_conv = sample_ext <<< SHIFT;

    assign ready  = (state_q == ST_COLLECT) && en && !flush;
    assign accept = ready && sample_valid;

    // Next-state, collection buffer writes and the launch copy into frame_data.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        sample_idx_d  = sample_idx_q;
        frame_count_d = frame_count_q;
        frame_data_d  = frame_data_q;
        fft_start_d   = 1'b0;
        buf_d         = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (flush) begin
                    sample_idx_d = '0;
                end else if (accept) begin
                    buf_d[sample_idx_q] = sample_conv;
                    if (sample_idx_q == LAST_IDX) begin
                        // Copy includes the sample landing this very edge.
                        for (int k = 0; k < N; k++) begin
                            frame_data_d[(N-k)*WIDTH-1 -: WIDTH] = buf_d[k];
                        end
                        sample_idx_d  = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        fft_start_d   = 1'b1;
                        state_d       = ST_LAUNCH;
                    end else begin
                        sample_idx_d = sample_idx_q + 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                if (HOLDOFF > 0) begin
                    hold_cnt_d = HOLD_LOAD;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_COLLECT;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; rst clears everything immediately, including fft_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            sample_idx_q  <= '0;
            frame_count_q <= '0;
            frame_data_q  <= '0;
            fft_start_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            sample_idx_q  <= sample_idx_d;
            frame_count_q <= frame_count_d;
            frame_data_q  <= frame_data_d;
            fft_start_q   <= fft_start_d;
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign sample_ready = ready;
    assign frame_data   = frame_data_q;
    assign fft_start    = fft_start_q;
    assign sample_idx   = sample_idx_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Testbench for fft_input_framer: directed phases with random data, checked
// every cycle against a frame-level reference model.
module tb_fft_input_framer;

    localparam int N        = 32;
    localparam int IN_WIDTH = 8;
    localparam int IN_FRAC  = 4;
    localparam int WIDTH    = 16;
    localparam int OUT_FRAC = 8;
    localparam int HOLDOFF  = 4;
    localparam int FW       = N * WIDTH;
    localparam int PERIOD   = N + 1 + HOLDOFF;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                flush;
    logic                sample_valid;
    logic [IN_WIDTH-1:0] sample_in;
    logic                sample_ready;
    logic [FW-1:0]       frame_data;
    logic                fft_start;
    logic [4:0]          sample_idx;
    logic [15:0]         frame_count;

    int checks = 0;
    int errors = 0;

    fft_input_framer #(
        .N(N), .IN_WIDTH(IN_WIDTH), .IN_FRAC(IN_FRAC),
        .WIDTH(WIDTH), .OUT_FRAC(OUT_FRAC), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .sample_ready(sample_ready), .frame_data(frame_data),
        .fft_start(fft_start), .sample_idx(sample_idx),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: started = left IDLE, block = cycles of forced not-ready
    // remaining after a launch, slots = frame being collected.
    bit               m_started;
    int               m_block;
    int               m_idx;
    int               m_count;
    bit               m_start;
    logic [WIDTH-1:0] m_slot  [N];
    logic [WIDTH-1:0] m_frame [N];

    int cyc_n = 0;
    int start_cycles[$];
    bit rdy_hist[$];

    function automatic logic [WIDTH-1:0] to_out(input logic [IN_WIDTH-1:0] s);
        int v;
        v = int'($signed(s)) * (1 << (OUT_FRAC - IN_FRAC));
        return WIDTH'(v);
    endfunction

    function automatic logic [FW-1:0] m_packed();
        logic [FW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[(N-k)*WIDTH-1 -: WIDTH] = m_frame[k];
        return v;
    endfunction

    task automatic m_reset();
        m_started = 0;
        m_block   = 0;
        m_idx     = 0;
        m_count   = 0;
        m_start   = 0;
        for (int k = 0; k < N; k++) begin
            m_slot[k]  = '0;
            m_frame[k] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc(input logic e, input logic v, input logic [IN_WIDTH-1:0] d, input logic f);
        bit exp_rdy;
        bit acc;
        en = e; sample_valid = v; sample_in = d; flush = f;
        #1;
        exp_rdy = m_started && (m_block == 0) && e && !f;
        check("sample_ready", FW'(sample_ready), FW'(exp_rdy));
        rdy_hist.push_back(sample_ready);
        acc = exp_rdy && v;
        @(posedge clk);
        m_start = 0;
        if (!m_started) begin
            if (e) m_started = 1;
        end else if (m_block > 0) begin
            m_block--;
        end else if (acc) begin
            m_slot[m_idx] = to_out(d);
            if (m_idx == N - 1) begin
                m_frame = m_slot;
                m_count = (m_count + 1) % 65536;
                m_idx   = 0;
                m_block = 1 + HOLDOFF;
                m_start = 1;
            end else begin
                m_idx++;
            end
        end else if (f) begin
            m_idx = 0;
        end
        #1;
        check("fft_start",   FW'(fft_start),   FW'(m_start));
        check("sample_idx",  FW'(sample_idx),  FW'(m_idx));
        check("frame_count", FW'(frame_count), FW'(m_count));
        check("frame_data",  frame_data,       m_packed());
        if (fft_start === 1'b1) start_cycles.push_back(cyc_n + 1);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_fft_start"},   FW'(fft_start),    '0);
        check({tag, "_frame_data"},  frame_data,        '0);
        check({tag, "_frame_count"}, FW'(frame_count),  '0);
        check({tag, "_sample_idx"},  FW'(sample_idx),   '0);
        check({tag, "_ready"},       FW'(sample_ready), '0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [IN_WIDTH-1:0] fmt_data [4];
        logic [FW-1:0]       snap;
        int                  n0;
        int                  target;
        int                  lows;

        rst = 1'b1; en = 1'b0; flush = 1'b0; sample_valid = 1'b0; sample_in = '0;
        m_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_frame_data",  frame_data,        '0);
        check("rst_fft_start",   FW'(fft_start),    '0);
        check("rst_ready",       FW'(sample_ready), '0);
        check("rst_sample_idx",  FW'(sample_idx),   '0);
        check("rst_frame_count", FW'(frame_count),  '0);
        rst = 1'b0;

        cyc(0, 0, '0, 0);
        cyc(1, 0, '0, 0);
        #1;
        check("ready_after_en", FW'(sample_ready), FW'(1'b1));
        @(negedge clk);

        // Format and packing
        fmt_data[0] = 8'h10; fmt_data[1] = 8'h80; fmt_data[2] = 8'h7F; fmt_data[3] = 8'hFF;
        n0 = start_cycles.size();
        for (int k = 0; k < N; k++) cyc(1, 1, (k < 4) ? fmt_data[k] : 8'h00, 0);
        check("fmt_start_cycle", FW'(start_cycles[$]), FW'(cyc_n));
        check("fmt_slice0", FW'(frame_data[FW-1 -: WIDTH]),          FW'(16'h0100));
        check("fmt_slice1", FW'(frame_data[FW-WIDTH-1 -: WIDTH]),    FW'(16'hF800));
        check("fmt_slice2", FW'(frame_data[FW-2*WIDTH-1 -: WIDTH]),  FW'(16'h07F0));
        check("fmt_slice3", FW'(frame_data[FW-3*WIDTH-1 -: WIDTH]),  FW'(16'hFFF0));
        check("fmt_rest",   FW'(frame_data[FW-4*WIDTH-1:0]),         '0);
        check("fmt_count",  FW'(frame_count), FW'(16'd1));
        repeat (6) cyc(1, 0, '0, 0);
        check("fmt_one_pulse", FW'(start_cycles.size() - n0), FW'(1));

        // Throughput and hold-off with continuous valid
        n0 = start_cycles.size();
        repeat (4 * PERIOD + 10) cyc(1, 1, 8'(m_idx), 0);
        check("tp_num_starts", FW'(start_cycles.size() - n0 >= 4), FW'(1'b1));
        for (int i = n0 + 1; i < start_cycles.size(); i++) begin
            check("tp_period", FW'(start_cycles[i] - start_cycles[i-1]), FW'(PERIOD));
            lows = 0;
            for (int c = start_cycles[i-1]; c < start_cycles[i]; c++) if (!rdy_hist[c]) lows++;
            check("tp_ready_low", FW'(lows), FW'(1 + HOLDOFF));
        end

        // Flush mid-frame to get back to slot 0, then pause and stability
        cyc(1, 0, '0, 1);
        check("flush_mid_idx", FW'(sample_idx), '0);
        snap = m_packed();
        repeat (16) cyc(1, 1, 8'($urandom), 0);
        repeat (10) cyc(0, 1, 8'($urandom), 0);
        check("pause_idx",   FW'(sample_idx), FW'(16));
        check("pause_frame", frame_data, snap);
        repeat (16) cyc(1, 1, 8'($urandom), 0);
        check("pause_launch", FW'(fft_start), FW'(1'b1));
        snap = m_packed();
        repeat (HOLDOFF + 1) cyc(1, 0, '0, 0);
        repeat (20) cyc(1, 1, 8'($urandom), 0);
        check("stable_frame", frame_data, snap);
        check("mid_idx", FW'(sample_idx), FW'(20));

        // Asynchronous reset mid-frame
        async_reset("rst_mid");
        cyc(1, 0, '0, 0);

        // Flush coinciding with sample 31
        repeat (N - 1) cyc(1, 1, 8'($urandom), 0);
        cyc(1, 1, 8'($urandom), 1);
        check("flush_idx",   FW'(sample_idx),  '0);
        check("flush_count", FW'(frame_count), '0);
        check("flush_start", FW'(fft_start),   '0);
        repeat (N) cyc(1, 1, 8'($urandom), 0);
        check("post_flush_launch", FW'(fft_start),   FW'(1'b1));
        check("post_flush_count",  FW'(frame_count), FW'(16'd1));

        // Asynchronous reset while fft_start is high
        async_reset("rst_launch");
        cyc(1, 0, '0, 0);

        // Random valid/en/data over several frames
        target = m_count + 3;
        for (int i = 0; i < 3000 && m_count != target; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 8'($urandom), 0);
        end
        check("random_frames", FW'(frame_count), FW'(target));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
